usb_rx_wire_recovery: RTL and testbench
=======================================

Name: usb_rx_wire_recovery

Overview:
- Parametrised successor to the SIE wire-receive front end.
- Recovers the bit clock from the differential USB pair by oversampling and samples each bit at mid-period.
- Queues samples in a depth-configurable FIFO and hands them to the SIE receiver over a ready/write-enable handshake.
- Adds a sticky overflow flag, FIFO fill-level reporting, explicit sample-counter wrap for any oversample ratio, and a saturating single-pulse no-activity timeout.

Parameters:
- FS_OVERSAMPLE, 4: clk cycles per full-speed bit; even, >=4.
- LS_OVERSAMPLE, 32: clk cycles per low-speed bit; even, >=FS_OVERSAMPLE.
- FIFO_DEPTH, 4: sample FIFO entries; power of 2, >=2.
- RX_EDGE_TOUT, 3: bit periods without an edge before rx-active clears.
- RX_PACKET_TOUT, 18: bit periods of no activity before the timeout pulse.
- TOUT_CNT_W, 16: timeout counter width; must hold RX_PACKET_TOUT*LS_OVERSAMPLE+1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- rx_bits_in  in  2  raw {D+,D-} line state; asynchronous to clk.
- full_speed_rate  in  1  1 = FS oversample ratio, 0 = LS.
- tx_wire_active_drive  in  1  transmitter driving the wire; blanks receive.
- no_activity_time_out_enable  in  1  arms the timeout counter.
- sie_rx_rdy_in  in  1  SIE receiver ready for a sample.
- overflow_clr  in  1  clears fifo_overflow.
- rx_bits_out  out  2  sample delivered to the SIE.
- rx_wire_active  out  1  rx-active qualifier for rx_bits_out.
- sie_rx_wen  out  1  one-cycle write strobe to the SIE.
- rx_data_in_tick  out  1  toggles at every sample point.
- no_activity_time_out  out  1  one-cycle timeout pulse.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- fifo_overflow  out  1  sticky: a sample was dropped.

Behaviour:
- Reset: all outputs 0, FIFO empty, pointers 0, state IDLE, all counters 0.
- Input path: rx_bits_in passes through two registers, s1 then s2.
  - edge = (s1 != s2) && !tx_wire_active_drive.
  - The sampled data is s2 delayed one more cycle (s3).
- Sample counter: width $clog2(LS_OVERSAMPLE); OS = FS_OVERSAMPLE if full_speed_rate, else LS_OVERSAMPLE.
  - On edge: counter <= 0.
  - Otherwise: counter <= (counter == OS-1) ? 0 : counter+1.
- Sample point: counter == OS/2.
  - rx_data_in_tick toggles.
  - If !tx_wire_active_drive, push {active_d, s3}. active_d is the rx-active flag delayed one cycle.
- rx-active flag:
  - Set on edge and reset of its counter (8 bit).
  - Cleared when its counter reaches RX_EDGE_TOUT*OS without an edge.
  - The counter saturates at that value.
- FIFO: circular buffer of 3-bit entries.
  - Push when full: entry dropped and fifo_overflow <= 1, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: level unchanged.
  - fifo_overflow stays set until rst, or until overflow_clr is asserted in a cycle with no new drop; a new drop wins.
  - fifo_level is registered and updates the cycle after a push or pop.
- Output FSM:
  - IDLE: if level != 0, go to WAIT_RDY.
  - WAIT_RDY: if sie_rx_rdy_in, pop the head into rx_bits_out/rx_wire_active, set sie_rx_wen <= 1, go to WRITE.
  - WRITE: sie_rx_wen <= 0, go to IDLE.
  - Minimum 3 cycles per sample; rx_bits_out and rx_wire_active hold between writes.
- Timeout counter (TOUT_CNT_W bits):
  - Clears on tx_wire_active_drive, edge, or !no_activity_time_out_enable; otherwise increments.
  - no_activity_time_out = 1 for exactly the one cycle after the counter equals RX_PACKET_TOUT*OS.
  - The counter then saturates at RX_PACKET_TOUT*OS+1, giving no further pulses until it is cleared.
- Rate change mid-packet: counter compares use the new OS immediately.
  - A counter value >= OS wraps to 0 on the next non-edge cycle.

Decomposition:
- Shared package usb_sie_pkg:
  - FS/LS oversample defaults.
  - RX_EDGE_TOUT and RX_PACKET_TOUT defaults.
  - Line-state encodings J/K/SE0.
  - Output FSM state enum.
- One sub-module, usb_rx_sample_fifo: parametrised circular buffer with level, full, empty and overflow.
- The top level holds the synchroniser, clock recovery, output FSM and timeout counter.

Test Plan:
- FS, continuous J/K alternation every 4 clk, sie_rx_rdy_in=1 -> one push per bit, sampled 2 clk after each edge; sie_rx_wen pulses carry alternating 2'b10/2'b01; rx_wire_active=1 after the first sample.
- LS, edges every 32 clk then line idle -> samples at counter 16; rx_wire_active returns 0 on samples taken more than 96 clk after the last edge.
- FIFO_DEPTH=4, sie_rx_rdy_in=0 for 6 FS bits -> fifo_level reaches 4; fifo_overflow=1 at the 5th push. Then overflow_clr for 1 cycle with no drop -> flag 0; level drains 4 to 0 when ready returns.
- Enable=1, no edges, FS -> no_activity_time_out pulses once, 1 cycle, 73 cycles after enable (counter reaches 72); no second pulse over the next 1000 cycles.
- tx_wire_active_drive=1 while rx_bits_in toggles -> no pushes, no edges, timeout counter held at 0; rx_data_in_tick still toggles.
- rst asserted mid-packet with level=3 -> next cycle all outputs 0, level 0, FSM in IDLE.

Source files
------------

// File: rtl/usb_sie_pkg.sv
// Shared definitions for the USB SIE receive path.
// Holds the oversample and timeout defaults, the {D+,D-} line-state
// encodings and the output FSM state type used by usb_rx_wire_recovery.
package usb_sie_pkg;

    // Oversample ratios: clk cycles per bit.
    localparam int FS_OVERSAMPLE_DEF  = 4;
    localparam int LS_OVERSAMPLE_DEF  = 32;

    // Timeouts, in bit periods.
    localparam int RX_EDGE_TOUT_DEF   = 3;
    localparam int RX_PACKET_TOUT_DEF = 18;

    // Line states as seen on {D+,D-} (full-speed polarity).
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    // Output FSM that hands queued samples to the SIE receiver.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_RDY = 2'd1,
        ST_WRITE    = 2'd2
    } rxOutState_t;

endpackage

// File: rtl/usb_rx_sample_fifo.sv
// Circular sample buffer between the clock-recovery front end and the
// output FSM.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push          write pushData this cycle (dropped when full)
//   pushData      entry to store
//   pop           remove the head entry (ignored when empty)
//   overflowClr   clears the sticky overflow flag
//   popData       current head entry
//   level         registered occupancy, 0..DEPTH
//   overflow      sticky: a push was dropped because the buffer was full
module usb_rx_sample_fifo
    import usb_sie_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    input  logic                     overflowClr,
    output logic [WIDTH-1:0]         popData,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             full;
    logic             empty;
    logic             doPush;
    logic             doPop;
    logic             drop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    // A push into a full buffer is dropped even when a pop frees a slot in
    // the same cycle; the pop still happens.
    assign doPush  = push && !full;
    assign doPop   = pop && !empty;
    assign drop    = push && full;
    assign popData = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (doPush && !doPop) begin
                level <= level + 1'b1;
            end else if (doPop && !doPush) begin
                level <= level - 1'b1;
            end
            // A fresh drop wins over a clear request in the same cycle.
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflowClr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/usb_rx_wire_recovery.sv
// USB wire-receive front end: synchronises the raw {D+,D-} pair, recovers
// the bit clock by oversampling, samples each bit mid-period, queues the
// samples and hands them to the SIE receiver. Also tracks line activity and
// raises a single no-activity timeout pulse.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rx_bits_in                    raw {D+,D-}, asynchronous to clk
//   full_speed_rate               1 = FS oversample ratio, 0 = LS
//   tx_wire_active_drive          our transmitter owns the wire; blanks rx
//   no_activity_time_out_enable   arms the timeout counter
//   sie_rx_rdy_in                 SIE can accept a sample
//   overflow_clr                  clears fifo_overflow
//   rx_bits_out, rx_wire_active   sample delivered to the SIE + qualifier
//   sie_rx_wen                    one-cycle write strobe to the SIE
//   rx_data_in_tick               toggles at every sample point
//   no_activity_time_out          one-cycle timeout pulse
//   fifo_level, fifo_overflow     FIFO occupancy and sticky drop flag
//   dbgState                      output FSM state
//
// SIE handshake: the FSM waits for sie_rx_rdy_in only while it holds a
// queued sample; in the cycle it sees ready it pops the head, and on the
// next cycle rx_bits_out/rx_wire_active carry that sample with sie_rx_wen
// high for exactly one cycle. Outputs hold their value between writes and
// a new write is at least three cycles after the previous one.
module usb_rx_wire_recovery
    import usb_sie_pkg::*;
#(
    parameter int FS_OVERSAMPLE  = FS_OVERSAMPLE_DEF,
    parameter int LS_OVERSAMPLE  = LS_OVERSAMPLE_DEF,
    parameter int FIFO_DEPTH     = 4,
    parameter int RX_EDGE_TOUT   = RX_EDGE_TOUT_DEF,
    parameter int RX_PACKET_TOUT = RX_PACKET_TOUT_DEF,
    parameter int TOUT_CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    rx_bits_in,
    input  logic                          full_speed_rate,
    input  logic                          tx_wire_active_drive,
    input  logic                          no_activity_time_out_enable,
    input  logic                          sie_rx_rdy_in,
    input  logic                          overflow_clr,
    output logic [1:0]                    rx_bits_out,
    output logic                          rx_wire_active,
    output logic                          sie_rx_wen,
    output logic                          rx_data_in_tick,
    output logic                          no_activity_time_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          fifo_overflow,
    output rxOutState_t                   dbgState
);

    localparam int CNT_W = $clog2(LS_OVERSAMPLE);

    localparam logic [CNT_W-1:0] FS_LAST = CNT_W'(FS_OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] LS_LAST = CNT_W'(LS_OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] FS_MID  = CNT_W'(FS_OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] LS_MID  = CNT_W'(LS_OVERSAMPLE / 2);

    localparam logic [7:0] FS_EDGE_LIM = 8'(RX_EDGE_TOUT * FS_OVERSAMPLE);
    localparam logic [7:0] LS_EDGE_LIM = 8'(RX_EDGE_TOUT * LS_OVERSAMPLE);

    localparam logic [TOUT_CNT_W-1:0] FS_TOUT_LIM = TOUT_CNT_W'(RX_PACKET_TOUT * FS_OVERSAMPLE);
    localparam logic [TOUT_CNT_W-1:0] LS_TOUT_LIM = TOUT_CNT_W'(RX_PACKET_TOUT * LS_OVERSAMPLE);

    // Synchroniser and data delay.
    logic [1:0]            s1;
    logic [1:0]            s2;
    logic [1:0]            s3;
    logic                  edgeDet;

    // Clock recovery.
    logic [CNT_W-1:0]      sampleCnt;
    logic [CNT_W-1:0]      osLast;
    logic [CNT_W-1:0]      osMid;
    logic                  samplePoint;

    // Line activity.
    logic [7:0]            activeCnt;
    logic [7:0]            edgeLim;
    logic                  rxActive;
    logic                  activeD;

    // Timeout.
    logic [TOUT_CNT_W-1:0] toutCnt;
    logic [TOUT_CNT_W-1:0] toutLim;
    logic                  toutClr;

    // FIFO / output FSM.
    logic                  fifoPush;
    logic [2:0]            fifoHead;
    logic                  popFifo;
    logic                  wenNext;
    rxOutState_t           state;
    rxOutState_t           nextState;

    // Rate-dependent limits switch immediately; counters already past the
    // new limit wrap or saturate on their next update.
    always_comb begin
        osLast  = full_speed_rate ? FS_LAST     : LS_LAST;
        osMid   = full_speed_rate ? FS_MID      : LS_MID;
        edgeLim = full_speed_rate ? FS_EDGE_LIM : LS_EDGE_LIM;
        toutLim = full_speed_rate ? FS_TOUT_LIM : LS_TOUT_LIM;
    end

    assign edgeDet     = (s1 != s2) && !tx_wire_active_drive;
    assign samplePoint = (sampleCnt == osMid);
    assign fifoPush    = samplePoint && !tx_wire_active_drive;
    assign toutClr     = tx_wire_active_drive || edgeDet || !no_activity_time_out_enable;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= LINE_SE0;
            s2 <= LINE_SE0;
            s3 <= LINE_SE0;
        end else begin
            s1 <= rx_bits_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Sample counter: realigned on every edge so the sample lands mid-bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sampleCnt       <= '0;
            rx_data_in_tick <= 1'b0;
        end else begin
            if (edgeDet || (sampleCnt >= osLast)) begin
                sampleCnt <= '0;
            end else begin
                sampleCnt <= sampleCnt + 1'b1;
            end
            if (samplePoint) begin
                rx_data_in_tick <= ~rx_data_in_tick;
            end
        end
    end

    // rx-active: set by any edge, cleared after RX_EDGE_TOUT quiet bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            activeCnt <= '0;
            rxActive  <= 1'b0;
            activeD   <= 1'b0;
        end else begin
            if (edgeDet) begin
                rxActive  <= 1'b1;
                activeCnt <= '0;
            end else if (activeCnt >= edgeLim) begin
                rxActive  <= 1'b0;
                activeCnt <= edgeLim;
            end else begin
                activeCnt <= activeCnt + 8'd1;
            end
            // Delayed so the qualifier lines up with s3.
            activeD <= rxActive;
        end
    end

    // Counter stops at limit+1 so exactly one pulse is produced per quiet
    // period.
    always_ff @(posedge clk) begin
        if (rst) begin
            toutCnt              <= '0;
            no_activity_time_out <= 1'b0;
        end else begin
            no_activity_time_out <= (toutCnt == toutLim);
            if (toutClr) begin
                toutCnt <= '0;
            end else if (toutCnt <= toutLim) begin
                toutCnt <= toutCnt + 1'b1;
            end
        end
    end

    usb_rx_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (3)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (fifoPush),
        .pushData    ({activeD, s3}),
        .pop         (popFifo),
        .overflowClr (overflow_clr),
        .popData     (fifoHead),
        .level       (fifo_level),
        .overflow    (fifo_overflow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            sie_rx_wen     <= 1'b0;
            rx_bits_out    <= 2'b00;
            rx_wire_active <= 1'b0;
        end else begin
            state      <= nextState;
            sie_rx_wen <= wenNext;
            if (popFifo) begin
                {rx_wire_active, rx_bits_out} <= fifoHead;
            end
        end
    end

    always_comb begin
        nextState = state;
        popFifo   = 1'b0;
        wenNext   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fifo_level != '0) begin
                    nextState = ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                if (sie_rx_rdy_in) begin
                    popFifo   = 1'b1;
                    wenNext   = 1'b1;
                    nextState = ST_WRITE;
                end
            end
            ST_WRITE: begin
                nextState = ST_IDLE;
            end
            default: begin
                nextState = ST_IDLE;
            end
        endcase
    end

    assign dbgState = state;

endmodule

// File: tb/tb_usb_rx_wire_recovery.sv
// Directed bench for usb_rx_wire_recovery with default parameters
// (FS=4, LS=32, depth 4, edge timeout 3 bits, packet timeout 18 bits).
module tb_usb_rx_wire_recovery;
    import usb_sie_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  rx_bits_in;
    logic        full_speed_rate;
    logic        tx_wire_active_drive;
    logic        no_activity_time_out_enable;
    logic        sie_rx_rdy_in;
    logic        overflow_clr;
    logic [1:0]  rx_bits_out;
    logic        rx_wire_active;
    logic        sie_rx_wen;
    logic        rx_data_in_tick;
    logic        no_activity_time_out;
    logic [2:0]  fifo_level;
    logic        fifo_overflow;
    rxOutState_t dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [2:0] exp_q[$];
    logic [2:0] cap_q[$];
    int         pulse_cnt = 0;

    usb_rx_wire_recovery dut (
        .clk                         (clk),
        .rst                         (rst),
        .rx_bits_in                  (rx_bits_in),
        .full_speed_rate             (full_speed_rate),
        .tx_wire_active_drive        (tx_wire_active_drive),
        .no_activity_time_out_enable (no_activity_time_out_enable),
        .sie_rx_rdy_in               (sie_rx_rdy_in),
        .overflow_clr                (overflow_clr),
        .rx_bits_out                 (rx_bits_out),
        .rx_wire_active              (rx_wire_active),
        .sie_rx_wen                  (sie_rx_wen),
        .rx_data_in_tick             (rx_data_in_tick),
        .no_activity_time_out        (no_activity_time_out),
        .fifo_level                  (fifo_level),
        .fifo_overflow               (fifo_overflow),
        .dbgState                    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    // Capture every SIE write and every timeout pulse on the falling edge.
    always @(negedge clk) begin
        if (sie_rx_wen) cap_q.push_back({rx_wire_active, rx_bits_out});
        if (no_activity_time_out) pulse_cnt++;
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Skip leading idle-J-inactive samples, then compare against exp_q.
    task automatic check_stream(input string tag, input int start);
        int idx;
        idx = start;
        while (idx < cap_q.size() && cap_q[idx] == 3'b010) idx++;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (idx + i < cap_q.size())
                check($sformatf("%s[%0d]", tag, i), 32'(cap_q[idx + i]), 32'(exp_q[i]));
            else
                check($sformatf("%s[%0d] missing", tag, i), 32'hFFFF_FFFF, 32'(exp_q[i]));
        end
        exp_q.delete();
    endtask

    task automatic wait_level(input logic [2:0] lvl, input string tag);
        int k;
        k = 0;
        while (fifo_level != lvl && k < 40) begin
            tick(1);
            k++;
        end
        check(tag, 32'(fifo_level), 32'(lvl));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int start;
        int p0;
        int c0;
        int toggles;
        logic prev_tick;

        rst = 1'b1;
        rx_bits_in = LINE_J;
        full_speed_rate = 1'b1;
        tx_wire_active_drive = 1'b0;
        no_activity_time_out_enable = 1'b0;
        sie_rx_rdy_in = 1'b1;
        overflow_clr = 1'b0;
        tick(3);

        // Reset state
        check("rst_bits_out", 32'(rx_bits_out), 0);
        check("rst_active", 32'(rx_wire_active), 0);
        check("rst_wen", 32'(sie_rx_wen), 0);
        check("rst_tick", 32'(rx_data_in_tick), 0);
        check("rst_tout", 32'(no_activity_time_out), 0);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_ovf", 32'(fifo_overflow), 0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;

        // FS: 8 alternating bits K,J,... every 4 clk, then idle J.
        tick(40);
        start = cap_q.size();
        for (int b = 0; b < 8; b++) begin
            rx_bits_in = (b % 2 == 0) ? LINE_K : LINE_J;
            tick(4);
        end
        tick(30);
        for (int b = 0; b < 8; b++) exp_q.push_back((b % 2 == 0) ? 3'b101 : 3'b110);
        exp_q.push_back(3'b110);
        exp_q.push_back(3'b110);
        exp_q.push_back(3'b010);   // 12 clk after last edge: inactive
        check_stream("fs_stream", start);

        // LS: one J->K edge, then idle K. Samples 16,48,80 clk after the edge
        // stay active, 112 and 144 are past the 96-clk edge timeout.
        full_speed_rate = 1'b0;
        tick(200);
        start = cap_q.size();
        rx_bits_in = LINE_K;
        tick(170);
        exp_q.push_back(3'b101);
        exp_q.push_back(3'b101);
        exp_q.push_back(3'b101);
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b001);
        check_stream("ls_stream", start);

        // FIFO fill / overflow / clear / drain (FS, idle K samples).
        full_speed_rate = 1'b1;
        tick(20);
        sie_rx_rdy_in = 1'b0;
        wait_level(3'd4, "fifo_fill_level");
        check("ovf_before_drop", 32'(fifo_overflow), 0);
        tick(3);
        check("ovf_not_yet", 32'(fifo_overflow), 0);
        tick(1);
        check("ovf_on_drop", 32'(fifo_overflow), 1);
        check("level_stays_full", 32'(fifo_level), 4);
        tick(3);
        overflow_clr = 1'b1;       // same cycle as the next drop
        tick(1);
        overflow_clr = 1'b0;
        check("ovf_drop_wins", 32'(fifo_overflow), 1);
        tx_wire_active_drive = 1'b1;
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        check("ovf_cleared", 32'(fifo_overflow), 0);
        check("state_wait_rdy", 32'(dbg_state), 32'(ST_WAIT_RDY));
        sie_rx_rdy_in = 1'b1;
        tick(1);
        check("drain_level3", 32'(fifo_level), 3);
        check("drain_wen", 32'(sie_rx_wen), 1);
        check("drain_data", 32'({rx_wire_active, rx_bits_out}), 32'({1'b0, LINE_K}));
        tick(1);
        check("drain_wen_low", 32'(sie_rx_wen), 0);
        tick(2);
        check("drain_level2", 32'(fifo_level), 2);
        tick(3);
        check("drain_level1", 32'(fifo_level), 1);
        tick(3);
        check("drain_level0", 32'(fifo_level), 0);
        tick(3);
        check("drain_idle", 32'(dbg_state), 32'(ST_IDLE));

        // Transmit blanking: line toggles, nothing received, no timeout.
        no_activity_time_out_enable = 1'b1;
        p0 = pulse_cnt;
        c0 = cap_q.size();
        toggles = 0;
        prev_tick = rx_data_in_tick;
        for (int i = 0; i < 200; i++) begin
            if (i % 3 == 0) rx_bits_in = (rx_bits_in == LINE_K) ? LINE_J : LINE_K;
            tick(1);
            if (i < 40 && rx_data_in_tick != prev_tick) toggles++;
            prev_tick = rx_data_in_tick;
        end
        check("tx_tick_toggles", 32'(toggles), 10);
        rx_bits_in = LINE_K;
        tick(3);
        check("tx_no_pulse", 32'(pulse_cnt - p0), 0);
        check("tx_no_write", 32'(cap_q.size() - c0), 0);
        check("tx_level", 32'(fifo_level), 0);
        tx_wire_active_drive = 1'b0;
        no_activity_time_out_enable = 1'b0;
        tick(5);

        // Timeout: pulse 73 clk after enable, then silence.
        p0 = pulse_cnt;
        no_activity_time_out_enable = 1'b1;
        tick(72);
        check("tout_before", 32'(no_activity_time_out), 0);
        tick(1);
        check("tout_pulse", 32'(no_activity_time_out), 1);
        tick(1);
        check("tout_after", 32'(no_activity_time_out), 0);
        tick(1000);
        check("tout_single", 32'(pulse_cnt - p0), 1);
        no_activity_time_out_enable = 1'b0;

        // Reset mid-packet with level 3.
        sie_rx_rdy_in = 1'b0;
        tick(2);
        wait_level(3'd3, "pre_rst_level");
        check("pre_rst_state", 32'(dbg_state), 32'(ST_WAIT_RDY));
        rst = 1'b1;
        tick(1);
        check("mid_rst_bits_out", 32'(rx_bits_out), 0);
        check("mid_rst_active", 32'(rx_wire_active), 0);
        check("mid_rst_wen", 32'(sie_rx_wen), 0);
        check("mid_rst_tick", 32'(rx_data_in_tick), 0);
        check("mid_rst_tout", 32'(no_activity_time_out), 0);
        check("mid_rst_level", 32'(fifo_level), 0);
        check("mid_rst_ovf", 32'(fifo_overflow), 0);
        check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
